// File: rtl/act_cfg_pkg.sv
// Shared definitions for the ACT cell configuration loader: cell field layout,
// FSM state encoding and frame sizing.
package act_cfg_pkg;

  localparam int CELL_W = 8;

  // Cell field layout, bits 7..0: {D[3:0], B1, A1, B0, A0}
  localparam int OFF_A0 = 0;
  localparam int OFF_B0 = 1;
  localparam int OFF_A1 = 2;
  localparam int OFF_B1 = 3;
  localparam int OFF_D  = 4;
  localparam int D_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  function automatic int frame_len(input int num_cells);
    return num_cells * CELL_W;
  endfunction

endpackage

// File: rtl/act_cfg_if.sv
// Serial configuration handshake plus the committed parallel cell configuration.
interface act_cfg_if
  import act_cfg_pkg::*;
#(
  parameter int FRAME_W = frame_len(4)
);
  logic               cfg_start;
  logic               cfg_bit;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FRAME_W-1:0] cell_cfg;
  logic               cfg_done;
  logic               cfg_err;
  logic               busy;

  modport master (
    output cfg_start, cfg_bit, cfg_valid,
    input  cfg_ready, cell_cfg, cfg_done, cfg_err, busy
  );

  modport slave (
    input  cfg_start, cfg_bit, cfg_valid,
    output cfg_ready, cell_cfg, cfg_done, cfg_err, busy
  );
endinterface

// File: rtl/act_cfg_shifter.sv
// Shadow shift register, accepted-bit counter and running parity for one frame.
module act_cfg_shifter #(
  parameter int FRAME_W = 32,
  parameter int CNT_W   = $clog2(FRAME_W + 2)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_bit,
  output logic [FRAME_W-1:0] o_shadow,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_par
);

  logic [FRAME_W-1:0] r_shadow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_par;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      r_par <= r_par ^ i_bit;
      // The parity bit (beyond FRAME_W) only feeds the parity accumulator
      if (r_cnt < CNT_W'(FRAME_W))
        r_shadow <= {r_shadow[FRAME_W-2:0], i_bit};
    end
  end

  assign o_shadow = r_shadow;
  assign o_cnt    = r_cnt;
  assign o_par    = r_par;

endmodule

// File: rtl/act_cfg_loader.sv
// Loads a serial, even-parity configuration frame and commits it in parallel
// to the ACT cell select/data inputs only after the parity check succeeds.
module act_cfg_loader
  import act_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 4
) (
  input  logic      CLK,
  input  logic      CLR,
  act_cfg_if.slave  bus
);

  localparam int FRAME_W = frame_len(NUM_CELLS);
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [FRAME_W-1:0] r_cell;

  logic               w_en;
  logic               w_clr;
  logic               w_last;
  logic               w_par;
  logic [FRAME_W-1:0] w_shadow;
  logic [CNT_W-1:0]   w_cnt;

  // A start pulse restarts the frame in every state except the one-cycle CHECK
  assign w_clr  = bus.cfg_start && (r_state != ST_CHECK);
  assign w_en   = r_ready && bus.cfg_valid && !bus.cfg_start;
  assign w_last = (w_cnt == CNT_W'(FRAME_W));

  act_cfg_shifter #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_shifter (
    .i_clk    (CLK),
    .i_rst_n  (CLR),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_bit    (bus.cfg_bit),
    .o_shadow (w_shadow),
    .o_cnt    (w_cnt),
    .o_par    (w_par)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cell  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_start) begin
            r_state <= ST_SHIFT;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_en && w_last) begin
            r_state <= ST_CHECK;
            r_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          // w_par already includes the parity bit, so even frames read 0
          if (!w_par) begin
            r_cell  <= w_shadow;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_err   <= 1'b1;
            r_state <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (bus.cfg_start) begin
            r_state <= ST_SHIFT;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.cfg_done  = r_done;
  assign bus.cfg_err   = r_err;
  assign bus.cell_cfg  = r_cell;

endmodule

// File: tb/tb_act_cfg_loader.sv
// Randomised and directed bench for act_cfg_loader against a frame-level
// reference model (queue of accepted bits, committed on even total parity).
module tb_act_cfg_loader;
  import act_cfg_pkg::*;

  localparam int NC = 2;
  localparam int FW = frame_len(NC);

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  act_cfg_if #(.FRAME_W(FW)) bus ();

  act_cfg_loader #(.NUM_CELLS(NC)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 collecting, 2 checking, 3 error
  int          m_mode = 0;
  bit          m_q[$];
  logic [FW-1:0] m_cfg = '0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_edge(input bit clr, input bit st, input bit v, input bit b);
    logic [FW-1:0] d;
    bit            p;
    m_done = 1'b0;
    if (!clr) begin
      m_mode = 0; m_q.delete(); m_cfg = '0; m_err = 1'b0;
      return;
    end
    case (m_mode)
      0: if (st) begin m_mode = 1; m_q.delete(); m_err = 1'b0; end
      1: begin
        if (st) m_q.delete();
        else if (v) begin
          m_q.push_back(b);
          if (m_q.size() == FW + 1) m_mode = 2;
        end
      end
      2: begin
        d = '0;
        p = 1'b0;
        for (int i = 0; i < FW + 1; i++) p = p ^ m_q[i];
        for (int i = 0; i < FW; i++) d[FW-1-i] = m_q[i];
        if (!p) begin m_cfg = d; m_done = 1'b1; m_mode = 0; end
        else begin m_err = 1'b1; m_mode = 3; end
      end
      default: if (st) begin m_mode = 1; m_q.delete(); m_err = 1'b0; end
    endcase
  endfunction

  task automatic step(input bit st, input bit v, input bit b);
    bus.cfg_start = st;
    bus.cfg_valid = v;
    bus.cfg_bit   = b;
    @(posedge CLK);
    model_edge(CLR, st, v, b);
    #1;
    check_val("cell_cfg",  32'(bus.cell_cfg),  32'(m_cfg));
    check_val("cfg_done",  32'(bus.cfg_done),  32'(m_done));
    check_val("cfg_err",   32'(bus.cfg_err),   32'(m_err));
    check_val("cfg_ready", 32'(bus.cfg_ready), 32'(m_mode == 1));
    check_val("busy",      32'(bus.busy),      32'(m_mode != 0));
  endtask

  task automatic send_bits(input logic [FW-1:0] d, input bit p, input int max_gap);
    for (int i = FW - 1; i >= 0; i--) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b1, d[i]);
    end
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, p);
  endtask

  initial begin
    logic [FW-1:0] d;
    bit            p;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;

    // Reset state
    CLR = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_val("rst_cell_cfg", 32'(bus.cell_cfg), 32'h0);
    check_val("rst_busy",     32'(bus.busy),     32'h0);
    CLR = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Good frame 0xA53C (8 ones, parity 0)
    step(1'b1, 1'b0, 1'b0);
    send_bits(16'hA53C, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("a53c_cfg",  32'(bus.cell_cfg), 32'hA53C);
    check_val("a53c_done", 32'(bus.cfg_done), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check_val("a53c_done_pulse", 32'(bus.cfg_done), 32'h0);

    // Abort after 5 bits, then full 0x0F01 (5 ones, parity 1)
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    send_bits(16'h0F01, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("abort_cfg", 32'(bus.cell_cfg), 32'h0F01);

    // Bad parity on 0xA53C keeps previous cell_cfg
    step(1'b1, 1'b0, 1'b0);
    send_bits(16'hA53C, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("perr_err",  32'(bus.cfg_err),  32'h1);
    check_val("perr_cfg",  32'(bus.cell_cfg), 32'h0F01);
    check_val("perr_done", 32'(bus.cfg_done), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check_val("perr_busy", 32'(bus.busy), 32'h1);

    // Start from ERROR, gapped 0x1234 + parity 1, start during CHECK ignored
    step(1'b1, 1'b0, 1'b0);
    check_val("err_clr",   32'(bus.cfg_err),   32'h0);
    check_val("err_ready", 32'(bus.cfg_ready), 32'h1);
    send_bits(16'h1234, 1'b1, 3);
    step(1'b1, 1'b1, 1'b0);
    check_val("gap_cfg",  32'(bus.cell_cfg), 32'h1234);
    check_val("gap_done", 32'(bus.cfg_done), 32'h1);

    // Reset mid-frame after 9 bits; later bits ignored without start
    step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    CLR = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    check_val("mid_rst_cfg",   32'(bus.cell_cfg),  32'h0);
    check_val("mid_rst_ready", 32'(bus.cfg_ready), 32'h0);
    CLR = 1'b1;
    repeat (20) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check_val("post_rst_cfg", 32'(bus.cell_cfg), 32'h0);

    // Random frames: aborts, wrong parity, gaps, start during CHECK
    for (int f = 0; f < 24; f++) begin
      d = FW'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, FW)) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      end
      send_bits(d, p, 2);
      step(1'($urandom_range(0, 2) == 0), 1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
